uart_transmitter: RTL and testbench
===================================

// Module: uart_transmitter
// PURPOSE
//  8N1 UART transmit side; counterpart of the board's UART receiver, same bit timing.
//  Accepts bytes from user logic into a small FIFO and serialises them on dout.
//  Frame order: start(0), 8 data bits LSB first, stop(1). Each bit is CLKS_PER_BIT clocks.
//  Sits between application logic and the TX pin; loopback into the receiver must recover every byte.
// PARAMETERS
//  CLKS_PER_BIT  279  clocks per bit; bit counter runs 0..CLKS_PER_BIT-1 (9 bits wide at default)
//  FIFO_DEPTH    4    byte FIFO entries; power of two, >=2
//  FIFO_AW       2    log2(FIFO_DEPTH)
// PORTS
//  clk      in   1  clock
//  rst      in   1  reset, synchronous, active-high
//  data_tx  in   8  byte to send; sampled when wr_en=1
//  wr_en    in   1  push data_tx into FIFO; ignored while full=1
//  full     out  1  FIFO full; writes are dropped
//  dout     out  1  serial line, registered, idle high
//  busy     out  1  1 when state!=IDLE or FIFO not empty
//  done     out  1  one-cycle pulse on the last cycle of a stop bit
//  state    out  2  FSM state (debug)
//  index    out  3  data bit being sent (debug)
// BEHAVIOUR
//  Reset: dout=1, busy=0, done=0, full=0, state=IDLE, counter=0, index=0, FIFO emptied.
//  Reset mid-frame: frame is truncated, dout=1 the cycle after rst, queued bytes are discarded.
//  FIFO: push if wr_en && !full. Pop when FSM is in IDLE with FIFO non-empty, or at the end of STOP
//   with FIFO non-empty. Push and pop in the same cycle are both honoured (count unchanged).
//   Push while full is dropped, even if a pop happens that cycle. Pointers wrap modulo FIFO_DEPTH.
//  FSM states (shared encodings): IDLE=0, START=1, DATA=2, STOP=3.
//   IDLE: counter=0, index=0, dout=1. If FIFO non-empty: pop into shift reg, go to START.
//   START: dout=0. counter++ until CLKS_PER_BIT-1, then counter=0 and go to DATA.
//   DATA: dout=shreg[index]. At counter==CLKS_PER_BIT-1: counter=0.
//    If index<7: index++. Else index=0 and go to STOP.
//   STOP: dout=1. At counter==CLKS_PER_BIT-1: done=1, counter=0.
//    If FIFO non-empty: pop and go directly to START (no idle gap). Else go to IDLE.
//  Latency: wr_en at cycle N into an empty FIFO with FSM idle -> FIFO non-empty N+1, pop N+1,
//   dout falls at N+2. Frame = 10*CLKS_PER_BIT cycles; back-to-back frames are contiguous.
//  dout is driven from a register decoded from the next state/bit, so there are no glitches
//   and the width of every bit is exact.
//  data_tx is captured at push; later changes on data_tx do not affect queued bytes.
//  done stays 0 except for the single cycle given above; full/busy are functions of
//   registered state.
// STRUCTURE
//  Shared package uart_pkg: FSM state localparams (IDLE/START/DATA/STOP),
//   default CLKS_PER_BIT=279 and HALF_BIT=139. These are shared with the receiver.
//  Sub-module uart_tx_fifo: sync FIFO with params DEPTH/AW.
//   Ports: clk, rst, push, din[7:0], pop, dout[7:0], empty, full.
//   Read data valid at dout while !empty (show-ahead).
//  Top: FSM, bit counter, index, 8-bit shift/hold reg, dout register.
// TESTING
//  1 Single byte 0xA5, CLKS_PER_BIT=279: wr_en at cycle 0 -> dout low cycles 2..280,
//    then bits 1,0,1,0,0,1,0,1 (279 cycles each), stop high, done at cycle 2791, busy=0 after.
//  2 Loopback into receiver: send 0x00, 0xFF, 0x55, 0x80 -> receiver valid four times
//    with identical data, no gaps between frames.
//  3 Overflow: 6 writes on consecutive cycles (0x01..0x06) into idle block -> 0x01..0x05
//    transmitted in order, 0x06 dropped, full=1 from cycle 5 until first STOP-end pop.
//  4 Simultaneous push/pop: write 0x3C exactly on the STOP-end cycle with 1 entry queued
//    -> both accepted, 0x3C sent after the queued byte.
//  5 Reset mid-frame: rst for 1 cycle during DATA index 3 -> dout=1 next cycle, state=IDLE,
//    FIFO empty; new 0x7E afterwards sent correctly.
//  6 Idle line: no writes for 5000 cycles -> dout=1, busy=0, done=0 throughout.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : FSM encodings and bit-timing constants shared by UART TX/RX.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef logic [1:0] uart_state_t;

    localparam uart_state_t IDLE  = 2'd0;
    localparam uart_state_t START = 2'd1;
    localparam uart_state_t DATA  = 2'd2;
    localparam uart_state_t STOP  = 2'd3;

    localparam int DEFAULT_CLKS_PER_BIT = 279;
    localparam int HALF_BIT             = 139;

endpackage
`default_nettype wire

// File: rtl/uart_transmitter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_transmitter_if
// Description : User-side byte port and status/debug signals of the UART TX.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_transmitter_if;
    import uart_pkg::*;

    logic [7:0]  data_tx;
    logic        wr_en;
    logic        full;
    logic        dout;
    logic        busy;
    logic        done;
    uart_state_t state;
    logic [2:0]  index;

    modport master (
        output data_tx, wr_en,
        input  full, dout, busy, done, state, index
    );

    modport slave (
        input  data_tx, wr_en,
        output full, dout, busy, done, state, index
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Show-ahead synchronous byte FIFO; DEPTH must equal 2**AW.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full
);
    localparam logic [AW:0] c_DEPTH = (AW+1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign full      = (r_count == c_DEPTH);
    assign empty     = (r_count == '0);
    // A push while full is dropped even if a pop frees a slot the same cycle.
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;
    assign dout      = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : uart_transmitter
// Description : 8N1 UART transmitter with byte FIFO; registered, glitch-free dout.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4,
    parameter int FIFO_AW      = 2
) (
    input  logic              clk,
    input  logic              rst,
    uart_transmitter_if.slave bus
);
    localparam int              c_CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(CLKS_PER_BIT - 1);

    uart_state_t     r_state;
    logic [c_CW-1:0] r_counter;
    logic [2:0]      r_index;
    logic [7:0]      r_shreg;
    logic            r_dout;

    uart_state_t     w_state_next;
    logic [c_CW-1:0] w_counter_next;
    logic [2:0]      w_index_next;
    logic            w_dout_next;
    logic            w_pop;
    logic            w_last;
    logic [7:0]      w_fifo_dout;
    logic            w_fifo_empty;
    logic            w_fifo_full;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.wr_en),
        .din   (bus.data_tx),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .empty (w_fifo_empty),
        .full  (w_fifo_full)
    );

    assign w_last = (r_counter == c_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_counter <= '0;
            r_index   <= '0;
            r_shreg   <= '0;
            r_dout    <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_counter <= w_counter_next;
            r_index   <= w_index_next;
            r_dout    <= w_dout_next;
            if (w_pop) r_shreg <= w_fifo_dout;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_counter_next = r_counter + c_CW'(1);
        w_index_next   = r_index;
        w_pop          = 1'b0;
        case (r_state)
            IDLE: begin
                w_counter_next = '0;
                w_index_next   = '0;
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_last) begin
                    w_counter_next = '0;
                    w_state_next   = DATA;
                end
            end
            DATA: begin
                if (w_last) begin
                    w_counter_next = '0;
                    if (r_index != 3'd7) begin
                        w_index_next = r_index + 3'd1;
                    end else begin
                        w_index_next = '0;
                        w_state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (w_last) begin
                    w_counter_next = '0;
                    // Chain straight into the next start bit so frames abut.
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = START;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next   = IDLE;
                w_counter_next = '0;
                w_index_next   = '0;
            end
        endcase

        // Line level is decoded from where the FSM will be next cycle.
        case (w_state_next)
            START:   w_dout_next = 1'b0;
            DATA:    w_dout_next = r_shreg[w_index_next];
            default: w_dout_next = 1'b1;
        endcase
    end

    always_comb begin
        bus.dout  = r_dout;
        bus.full  = w_fifo_full;
        bus.busy  = (r_state != IDLE) || !w_fifo_empty;
        bus.done  = (r_state == STOP) && w_last;
        bus.state = r_state;
        bus.index = r_index;
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_transmitter
// Description : Self-checking bench: cycle model of the serial line plus a line decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_transmitter;
    localparam int CPB   = 279;
    localparam int HALF  = uart_pkg::HALF_BIT;
    localparam int FRAME = 10 * CPB;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;
    uart_transmitter_if bus ();

    uart_transmitter #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .FIFO_AW      (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_done = -1;

    // Model: queued bytes, and position of the frame on the line (if any).
    logic [7:0] mq[$];
    bit         m_active = 0;
    int         m_pos    = 0;
    logic [7:0] m_byte   = '0;
    logic [7:0] m_sent[$];

    // Line decoder, as an independent receiver would see it.
    logic [7:0] rx_q[$];
    bit         rx_active = 0;
    int         rx_t0     = 0;
    logic [7:0] rx_sh     = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_edge(input logic r, input logic we, input logic [7:0] d);
        logic [7:0] popped;
        bit         did_pop;
        int         pre;
        popped = '0;
        if (r) begin
            mq.delete();
            m_active = 0;
            m_pos    = 0;
            return;
        end
        pre     = mq.size();
        did_pop = (pre > 0) && (!m_active || m_pos == FRAME - 1);
        if (m_active && m_pos == FRAME - 1) m_sent.push_back(m_byte);
        if (did_pop) popped = mq.pop_front();
        if (we && pre < DEPTH) mq.push_back(d);
        if (did_pop) begin
            m_active = 1;
            m_pos    = 0;
            m_byte   = popped;
        end else if (m_active) begin
            if (m_pos == FRAME - 1) m_active = 0;
            else m_pos++;
        end
    endtask

    task automatic check_outputs();
        logic       e_dout;
        logic [1:0] e_state;
        logic [2:0] e_index;
        int         b;
        b = m_pos / CPB;
        if (!m_active) begin
            e_dout = 1'b1; e_state = 2'd0; e_index = 3'd0;
        end else if (b == 0) begin
            e_dout = 1'b0; e_state = 2'd1; e_index = 3'd0;
        end else if (b <= 8) begin
            e_dout = m_byte[b-1]; e_state = 2'd2; e_index = 3'(b - 1);
        end else begin
            e_dout = 1'b1; e_state = 2'd3; e_index = 3'd0;
        end
        chk("dout",  32'(bus.dout),  32'(e_dout));
        chk("state", 32'(bus.state), 32'(e_state));
        chk("index", 32'(bus.index), 32'(e_index));
        chk("busy",  32'(bus.busy),  32'(m_active || mq.size() != 0));
        chk("full",  32'(bus.full),  32'(mq.size() == DEPTH));
        chk("done",  32'(bus.done),  32'(m_active && m_pos == FRAME - 1));
    endtask

    task automatic rx_step();
        int rel;
        int k;
        if (rx_active) begin
            rel = cyc - rx_t0;
            if (rel % CPB == HALF) begin
                k = rel / CPB;
                if (k == 0) chk("rx_start", 32'(bus.dout), 32'd0);
                else if (k <= 8) rx_sh[k-1] = bus.dout;
                else begin
                    chk("rx_stop", 32'(bus.dout), 32'd1);
                    rx_q.push_back(rx_sh);
                    rx_active = 0;
                end
            end
        end else if (bus.dout === 1'b0) begin
            rx_active = 1;
            rx_t0     = cyc;
        end
    endtask

    task automatic tick(input logic r, input logic we, input logic [7:0] d);
        rst         = r;
        bus.wr_en   = we;
        bus.data_tx = d;
        @(posedge clk);
        model_edge(r, we, d);
        @(negedge clk);
        cyc++;
        check_outputs();
        if (r) rx_active = 0;
        else rx_step();
        if (bus.done === 1'b1) last_done = cyc;
    endtask

    task automatic tick_to(input int t0, input int rel);
        while (cyc - t0 < rel) tick(1'b0, 1'b0, 8'h00);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_active || mq.size() != 0) && n < 6 * FRAME) begin
            tick(1'b0, 1'b0, 8'h00);
            n++;
        end
        repeat (3) tick(1'b0, 1'b0, 8'h00);
        chk("drain_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic clear_logs();
        rx_q.delete();
        m_sent.delete();
    endtask

    task automatic compare_rx(input string tag);
        chk({tag, "_count"}, 32'(rx_q.size()), 32'(m_sent.size()));
        for (int i = 0; i < rx_q.size() && i < m_sent.size(); i++)
            chk({tag, "_byte"}, 32'(rx_q[i]), 32'(m_sent[i]));
    endtask

    initial begin
        int         t0;
        int         n;
        bit         idle_bad;
        logic [7:0] t2 [4];
        logic [7:0] t4 [3];
        logic [7:0] rb;

        t2 = '{8'h00, 8'hFF, 8'h55, 8'h80};
        t4 = '{8'h91, 8'h4B, 8'h3C};
        rst = 1'b1; bus.wr_en = 1'b0; bus.data_tx = 8'h00;

        // Reset state
        repeat (3) tick(1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 8'h00);
        chk("rst_dout",  32'(bus.dout),  32'd1);
        chk("rst_busy",  32'(bus.busy),  32'd0);
        chk("rst_full",  32'(bus.full),  32'd0);
        chk("rst_state", 32'(bus.state), 32'd0);

        // Test 1: single 0xA5, bit-accurate timing
        clear_logs();
        t0 = cyc;
        tick(1'b0, 1'b1, 8'hA5);
        chk("t1_idle_c1", 32'(bus.dout), 32'd1);
        chk("t1_busy_c1", 32'(bus.busy), 32'd1);
        tick_to(t0, 2);              chk("t1_start_first", 32'(bus.dout), 32'd0);
        tick_to(t0, 1 + CPB);        chk("t1_start_last",  32'(bus.dout), 32'd0);
        tick_to(t0, 2 + CPB);        chk("t1_bit0", 32'(bus.dout), 32'd1);
        tick_to(t0, 2 + 2 * CPB);    chk("t1_bit1", 32'(bus.dout), 32'd0);
        tick_to(t0, 2 + 9 * CPB);    chk("t1_stop_state", 32'(bus.state), 32'd3);
        tick_to(t0, 2790);           chk("t1_done_early", 32'(bus.done), 32'd0);
        tick_to(t0, 2791);           chk("t1_done", 32'(bus.done), 32'd1);
        tick_to(t0, 2792);           chk("t1_busy_after", 32'(bus.busy), 32'd0);
        chk("t1_done_cycle", 32'(last_done - t0), 32'd2791);
        wait_idle();
        chk("t1_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) chk("t1_rx", 32'(rx_q[0]), 32'hA5);

        // Test 2: four back-to-back bytes recovered by the line decoder
        clear_logs();
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, t2[i]);
        wait_idle();
        chk("t2_rx_count", 32'(rx_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < rx_q.size(); i++) chk("t2_rx", 32'(rx_q[i]), 32'(t2[i]));

        // Test 3: overflow, sixth write dropped
        clear_logs();
        t0 = cyc;
        for (int i = 1; i <= 6; i++) begin
            tick(1'b0, 1'b1, 8'(i));
            if (cyc - t0 == 4) chk("t3_full_c4", 32'(bus.full), 32'd0);
            if (cyc - t0 == 5) chk("t3_full_c5", 32'(bus.full), 32'd1);
        end
        tick_to(t0, 2791);           chk("t3_full_stopend", 32'(bus.full), 32'd1);
        tick_to(t0, 2792);           chk("t3_full_after_pop", 32'(bus.full), 32'd0);
        wait_idle();
        chk("t3_rx_count", 32'(rx_q.size()), 32'd5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++) chk("t3_rx", 32'(rx_q[i]), 32'(i + 1));

        // Test 4: push on exactly the STOP-end cycle with one entry queued
        clear_logs();
        tick(1'b0, 1'b1, t4[0]);
        tick(1'b0, 1'b1, t4[1]);
        n = 0;
        while (!(m_active && m_pos == FRAME - 1) && n < 2 * FRAME) begin
            tick(1'b0, 1'b0, 8'h00);
            n++;
        end
        chk("t4_done_at_push", 32'(bus.done), 32'd1);
        tick(1'b0, 1'b1, t4[2]);
        chk("t4_restart", 32'(bus.state), 32'd1);
        wait_idle();
        chk("t4_rx_count", 32'(rx_q.size()), 32'd3);
        for (int i = 0; i < 3 && i < rx_q.size(); i++) chk("t4_rx", 32'(rx_q[i]), 32'(t4[i]));

        // Test 5: reset during DATA index 3 with bytes still queued
        clear_logs();
        tick(1'b0, 1'b1, 8'hC3);
        tick(1'b0, 1'b1, 8'h11);
        tick(1'b0, 1'b1, 8'h22);
        n = 0;
        while (!(m_active && m_pos == 4 * CPB + 100) && n < 2 * FRAME) begin
            tick(1'b0, 1'b0, 8'h00);
            n++;
        end
        chk("t5_index_before", 32'(bus.index), 32'd3);
        tick(1'b1, 1'b0, 8'h00);
        chk("t5_dout",  32'(bus.dout),  32'd1);
        chk("t5_state", 32'(bus.state), 32'd0);
        chk("t5_busy",  32'(bus.busy),  32'd0);
        tick(1'b0, 1'b0, 8'h00);
        clear_logs();
        tick(1'b0, 1'b1, 8'h7E);
        wait_idle();
        chk("t5_rx_count", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) chk("t5_rx", 32'(rx_q[0]), 32'h7E);

        // Test 6: idle line
        idle_bad = 0;
        for (int i = 0; i < 5000; i++) begin
            tick(1'b0, 1'b0, 8'(i));
            if (bus.dout !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) idle_bad = 1;
        end
        chk("t6_idle_line", 32'(idle_bad), 32'd0);

        // Random traffic with random gaps, including bursts that overflow
        clear_logs();
        for (int i = 0; i < 7; i++) begin
            n = (i % 3 == 2) ? 0 : int'($urandom_range(0, 1500));
            repeat (n) tick(1'b0, 1'b0, 8'h00);
            rb = 8'($urandom);
            tick(1'b0, 1'b1, rb);
        end
        wait_idle();
        compare_rx("rand_rx");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
